switch_allocator: RTL and testbench
===================================

# switch_allocator

Per-router wormhole switch allocator for the 3x3 mesh. It routes the head flit on each of the five input ports through the XY `routing_table` and arbitrates each output port round-robin among competing inputs. It holds each granted output for the whole packet until the tail flit transfers. It sits between the input buffers and the crossbar, and drives the crossbar selects and the per-input ready signals.

## Interface
- `ROUTER_ID`, default 0: this router's node address, `ADDR_SZ bits, values 0..8.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 5: input port i holds a valid flit.
- `in_head`, in, 5: flit on input i is a head; qualified by `in_valid[i]`.
- `in_tail`, in, 5: flit on input i is a tail; head and tail may both be set (single-flit packet).
- `in_dest`, in, 5*`ADDR_SZ: destination address for input i; sampled only with head.
- `in_ready`, out, 5: input i's flit transfers this cycle when `in_valid[i]` is also high.
- `out_ready`, in, 5: downstream port o can accept a flit.
- `out_valid`, out, 5: output o carries a flit this cycle.
- `xbar_sel`, out, 25: five 5-bit one-hot input selects, one per output (bits 5o+4..5o); all zero when the output is unlocked.
- `wd_err`, out, 1: watchdog error; only present in function when `SA_WATCHDOG_EN` is defined.

## Operation
- Port index order for inputs and outputs: 0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST. A `BITS_DIR direction code maps to the output index of that direction.
- Each input feeds `ROUTER_ID` and `in_dest[i]` to its own `routing_table` instance, which gives the requested output.
- An input requests its output when `in_valid & in_head` and the input is not already locked.
- Each output has two states:
  - IDLE: if any requests are present, pick the first requester at or after `rr_ptr[o]` (wrapping 4→0), register owner=i, go to LOCKED.
  - LOCKED: `out_valid[o] = in_valid[owner]`, `in_ready[owner] = out_ready[o]`, `xbar_sel` one-hot on owner. On a transfer with `in_tail` set: next state IDLE and `rr_ptr[o] = owner+1 mod 5`.
- While an input is locked, `in_head` is ignored (a head/tail flit only closes the packet).
- Unlocked inputs have `in_ready` = 0.
- One input holds at most one output at a time. Several outputs may lock different inputs in the same cycle.
- A destination equal to `ROUTER_ID` routes to LOCAL.

## Timing
- Reset values: all outputs IDLE, `rr_ptr` = 0, `in_ready` = 0, `out_valid` = 0, `xbar_sel` = 0, `wd_err` = 0.
- Head valid in cycle T on an IDLE output → LOCKED at T+1 → first transfer at T+1 at the earliest.
- Tail transfers in cycle T → IDLE at T+1; a new head may lock at T+2. This leaves a one-cycle bubble by design.
- When the owner's `in_valid` is low mid-packet, the lock holds and `out_valid` = 0.
- Reset asserted mid-packet drops all locks immediately. The packet is lost; upstream flushes.
- `in_ready`, `out_valid` and `xbar_sel` are combinational from lock state plus `out_ready` and `in_valid`. There is no combinational path from `in_dest` to any output.

## Configuration
- `SA_WATCHDOG_EN` defined:
  - Each output has an 8-bit stall counter. It counts cycles that are LOCKED with no transfer and clears on any transfer or on IDLE.
  - When a counter reaches 255, `wd_err` is set and stays set until reset. Routing is unaffected.
- `SA_WATCHDOG_EN` undefined: no counters, `wd_err` tied to 0.

## Structure
- Port indices (`P_LOCAL` .. `P_WEST`) go in the shared constants include, beside `ADDR_SZ, `BITS_DIR and the direction codes. A direction-to-index mapping function goes there too.
- The only sub-module is the existing `routing_table` (five instances). The per-output state and round-robin pointer are inline generate logic.

## Test plan
- `ROUTER_ID`=4; LOCAL head dest=5 with tail set, `out_ready`=all ones → EAST locks at T+1, `xbar_sel[14:10]`=00001, transfer at T+1, EAST IDLE at T+2.
- `ROUTER_ID`=4; NORTH and SOUTH heads both dest=3 at the same cycle, 3-flit packets, `rr_ptr`=0 → NORTH wins WEST. SOUTH waits and locks 2 cycles after NORTH's tail, and `rr_ptr[WEST]` becomes 2 then 4.
- `ROUTER_ID`=0, dest=0 → LOCAL output is locked. With `ROUTER_ID`=8, dest=2 → NORTH is locked.
- Mid-packet: `out_ready` low for 5 cycles → `in_ready` low for those cycles, lock kept, no flit lost or duplicated.
- `rst_n` pulsed low while locked → all outputs zero asynchronously; after release, a fresh head is allocated normally.
- With `SA_WATCHDOG_EN`: hold `out_ready`=0 for 255 locked cycles → `wd_err` rises and stays high after traffic resumes until reset.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// Shared constants for the mesh switch allocator: address/direction widths,
// direction codes, port indices and the direction-to-port mapping.
package switch_allocator_pkg;

  localparam int ADDR_SZ   = 4;
  localparam int BITS_DIR  = 3;
  localparam int NUM_PORTS = 5;
  localparam int PORT_SZ   = 3;

  localparam logic [BITS_DIR-1:0] DIR_NORTH = 3'd0;
  localparam logic [BITS_DIR-1:0] DIR_EAST  = 3'd1;
  localparam logic [BITS_DIR-1:0] DIR_SOUTH = 3'd2;
  localparam logic [BITS_DIR-1:0] DIR_WEST  = 3'd3;
  localparam logic [BITS_DIR-1:0] DIR_LOCAL = 3'd4;

  localparam logic [PORT_SZ-1:0] P_LOCAL = 3'd0;
  localparam logic [PORT_SZ-1:0] P_NORTH = 3'd1;
  localparam logic [PORT_SZ-1:0] P_EAST  = 3'd2;
  localparam logic [PORT_SZ-1:0] P_SOUTH = 3'd3;
  localparam logic [PORT_SZ-1:0] P_WEST  = 3'd4;

  typedef enum logic {
    OUT_IDLE,
    OUT_LOCKED
  } out_state_t;

  function automatic logic [PORT_SZ-1:0] dir_to_port(input logic [BITS_DIR-1:0] dir);
    case (dir)
      DIR_NORTH: return P_NORTH;
      DIR_EAST:  return P_EAST;
      DIR_SOUTH: return P_SOUTH;
      DIR_WEST:  return P_WEST;
      default:   return P_LOCAL;
    endcase
  endfunction

  function automatic logic [PORT_SZ-1:0] port_inc(input logic [PORT_SZ-1:0] p);
    return (p == P_WEST) ? P_LOCAL : p + 3'd1;
  endfunction

endpackage

// File: rtl/routing_table.sv
// XY dimension-order routing for the 3x3 mesh: resolve X first, then Y.
// Node address = 3*y + x; EAST is +x, SOUTH is +y.
module routing_table
  import switch_allocator_pkg::*;
(
  input  logic [ADDR_SZ-1:0]  router_id,
  input  logic [ADDR_SZ-1:0]  dest,
  output logic [BITS_DIR-1:0] dir
);

  function automatic logic [1:0] addr_x(input logic [ADDR_SZ-1:0] a);
    case (a)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] addr_y(input logic [ADDR_SZ-1:0] a);
    case (a)
      4'd0, 4'd1, 4'd2: return 2'd0;
      4'd3, 4'd4, 4'd5: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  logic [1:0] cur_x, cur_y, dst_x, dst_y;

  always_comb begin
    cur_x = addr_x(router_id);
    cur_y = addr_y(router_id);
    dst_x = addr_x(dest);
    dst_y = addr_y(dest);
    if (dst_x > cur_x)      dir = DIR_EAST;
    else if (dst_x < cur_x) dir = DIR_WEST;
    else if (dst_y > cur_y) dir = DIR_SOUTH;
    else if (dst_y < cur_y) dir = DIR_NORTH;
    else                    dir = DIR_LOCAL;
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin lock held head to tail.
// Optional stall watchdog enabled by defining SA_WATCHDOG_EN.
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter logic [ADDR_SZ-1:0] ROUTER_ID = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS-1:0]           in_head,
  input  logic [NUM_PORTS-1:0]           in_tail,
  input  logic [NUM_PORTS*ADDR_SZ-1:0]   in_dest,
  output logic [NUM_PORTS-1:0]           in_ready,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [NUM_PORTS*NUM_PORTS-1:0] xbar_sel,
  output logic                           wd_err
);

  logic [BITS_DIR-1:0] route_dir  [NUM_PORTS];
  logic [PORT_SZ-1:0]  route_port [NUM_PORTS];
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] in_locked;
  logic [NUM_PORTS-1:0] xfer;
  // own_mask[o] is the one-hot owner of output o, zero when unlocked
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] own_mask;

  genvar gi;

  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
    routing_table u_rt (
      .router_id (ROUTER_ID),
      .dest      (in_dest[gi*ADDR_SZ +: ADDR_SZ]),
      .dir       (route_dir[gi])
    );
    assign route_port[gi] = dir_to_port(route_dir[gi]);
    assign req[gi]        = in_valid[gi] & in_head[gi] & ~in_locked[gi];
  end

  always_comb begin
    in_locked = '0;
    in_ready  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      in_locked = in_locked | own_mask[o];
      in_ready  = in_ready | (own_mask[o] & {NUM_PORTS{out_ready[o]}});
    end
  end

`ifdef SA_WATCHDOG_EN
  logic [NUM_PORTS-1:0] stall_max;
`endif

  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
    out_state_t          state_reg, state_next;
    logic [PORT_SZ-1:0]  owner_reg, owner_next;
    logic [PORT_SZ-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [NUM_PORTS-1:0] req_here;
    logic                grant_found;
    logic [PORT_SZ-1:0]  grant_idx;
    logic                locked;

    assign locked        = (state_reg == OUT_LOCKED);
    assign own_mask[gi]  = locked ? (NUM_PORTS'(1) << owner_reg) : '0;
    assign xfer[gi]      = locked & in_valid[owner_reg] & out_ready[gi];
    assign out_valid[gi] = locked & in_valid[owner_reg];
    assign xbar_sel[gi*NUM_PORTS +: NUM_PORTS] = own_mask[gi];

    always_comb begin
      for (int i = 0; i < NUM_PORTS; i++)
        req_here[i] = req[i] && (route_port[i] == PORT_SZ'(gi));
    end

    // Scan from the farthest candidate back to rr_ptr so the nearest wins
    always_comb begin
      logic [3:0] sum;
      logic [PORT_SZ-1:0] cand;
      grant_found = 1'b0;
      grant_idx   = rr_ptr_reg;
      sum         = '0;
      cand        = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        sum  = {1'b0, rr_ptr_reg} + 4'(k);
        cand = (sum >= 4'd5) ? PORT_SZ'(sum - 4'd5) : PORT_SZ'(sum);
        if (req_here[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end

    always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      rr_ptr_next = rr_ptr_reg;
      case (state_reg)
        OUT_IDLE: begin
          if (grant_found) begin
            state_next = OUT_LOCKED;
            owner_next = grant_idx;
          end
        end
        OUT_LOCKED: begin
          if (xfer[gi] && in_tail[owner_reg]) begin
            state_next  = OUT_IDLE;
            rr_ptr_next = port_inc(owner_reg);
          end
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg  <= OUT_IDLE;
        owner_reg  <= '0;
        rr_ptr_reg <= '0;
      end else begin
        state_reg  <= state_next;
        owner_reg  <= owner_next;
        rr_ptr_reg <= rr_ptr_next;
      end
    end

`ifdef SA_WATCHDOG_EN
    logic [7:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stall_cnt_reg <= '0;
      else if (!locked || xfer[gi])
        stall_cnt_reg <= '0;
      else if (stall_cnt_reg != 8'hFF)
        stall_cnt_reg <= stall_cnt_reg + 8'd1;
    end

    assign stall_max[gi] = (stall_cnt_reg == 8'hFF);
`endif
  end

`ifdef SA_WATCHDOG_EN
  logic wd_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd_err_reg <= 1'b0;
    else if (|stall_max)
      wd_err_reg <= 1'b1;
  end

  assign wd_err = wd_err_reg;
`else
  assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: three routers (IDs 4, 0, 8) share stimulus.
// The watchdog scenario expects wd_err only when SA_WATCHDOG_EN is defined.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

`ifdef SA_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in_valid, in_head, in_tail, out_ready;
  logic [19:0] in_dest;
  logic [4:0]  rdy_a, ov_a, rdy_b, ov_b, rdy_c, ov_c;
  logic [24:0] sel_a, sel_b, sel_c;
  logic        wd_a, wd_b, wd_c;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  switch_allocator #(.ROUTER_ID(4'd4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail),
    .in_dest(in_dest), .in_ready(rdy_a), .out_ready(out_ready), .out_valid(ov_a),
    .xbar_sel(sel_a), .wd_err(wd_a));

  switch_allocator #(.ROUTER_ID(4'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail),
    .in_dest(in_dest), .in_ready(rdy_b), .out_ready(out_ready), .out_valid(ov_b),
    .xbar_sel(sel_b), .wd_err(wd_b));

  switch_allocator #(.ROUTER_ID(4'd8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail),
    .in_dest(in_dest), .in_ready(rdy_c), .out_ready(out_ready), .out_valid(ov_c),
    .xbar_sel(sel_c), .wd_err(wd_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid  = '0;
    in_head   = '0;
    in_tail   = '0;
    in_dest   = '0;
    out_ready = 5'b11111;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if ({ov_a, ov_b, ov_c} !== 15'd0) begin nerr++; $display("FAIL reset_out_valid got=%b want=0", {ov_a, ov_b, ov_c}); end
    nvec++; if ({rdy_a, rdy_b, rdy_c} !== 15'd0) begin nerr++; $display("FAIL reset_in_ready got=%b want=0", {rdy_a, rdy_b, rdy_c}); end
    nvec++; if ({sel_a, sel_b, sel_c} !== 75'd0) begin nerr++; $display("FAIL reset_xbar_sel got=%h want=0", {sel_a, sel_b, sel_c}); end
    nvec++; if ({wd_a, wd_b, wd_c} !== 3'b000) begin nerr++; $display("FAIL reset_wd_err got=%b want=000", {wd_a, wd_b, wd_c}); end
    nvec++; if (dut.g_out[4].rr_ptr_reg !== 3'd0) begin nerr++; $display("FAIL reset_rr_ptr got=%0d want=0", dut.g_out[4].rr_ptr_reg); end
    $display("test_reset done");
  endtask

  // LOCAL single-flit packet to node 5 from router 4 goes EAST
  task automatic test_single_flit();
    do_reset();
    in_valid[0] = 1'b1; in_head[0] = 1'b1; in_tail[0] = 1'b1; in_dest[3:0] = 4'd5;
    #1;
    nvec++; if (sel_a[14:10] !== 5'b00000) begin nerr++; $display("FAIL single_T_sel got=%b want=00000", sel_a[14:10]); end
    nvec++; if (rdy_a !== 5'b00000) begin nerr++; $display("FAIL single_T_ready got=%b want=00000", rdy_a); end
    tick();
    nvec++; if (sel_a[14:10] !== 5'b00001) begin nerr++; $display("FAIL single_T1_sel got=%b want=00001", sel_a[14:10]); end
    nvec++; if (ov_a !== 5'b00100) begin nerr++; $display("FAIL single_T1_out_valid got=%b want=00100", ov_a); end
    nvec++; if (rdy_a !== 5'b00001) begin nerr++; $display("FAIL single_T1_ready got=%b want=00001", rdy_a); end
    tick();
    clear_inputs();
    #1;
    nvec++; if (sel_a !== 25'd0) begin nerr++; $display("FAIL single_T2_idle got=%h want=0", sel_a); end
    $display("test_single_flit done");
  endtask

  // NORTH and SOUTH contend for WEST with 3-flit packets
  task automatic test_round_robin();
    do_reset();
    in_valid = 5'b01010; in_head = 5'b01010; in_dest[7:4] = 4'd3; in_dest[15:12] = 4'd3;
    #1;
    nvec++; if (sel_a[24:20] !== 5'b00000) begin nerr++; $display("FAIL rr_C0_sel got=%b want=00000", sel_a[24:20]); end
    tick();
    nvec++; if (sel_a[24:20] !== 5'b00010) begin nerr++; $display("FAIL rr_C1_sel got=%b want=00010", sel_a[24:20]); end
    nvec++; if (rdy_a !== 5'b00010) begin nerr++; $display("FAIL rr_C1_ready got=%b want=00010", rdy_a); end
    nvec++; if (ov_a !== 5'b10000) begin nerr++; $display("FAIL rr_C1_out_valid got=%b want=10000", ov_a); end
    tick(); in_head[1] = 1'b0; #1;
    nvec++; if (sel_a[24:20] !== 5'b00010) begin nerr++; $display("FAIL rr_C2_body_sel got=%b want=00010", sel_a[24:20]); end
    tick(); in_tail[1] = 1'b1; #1;
    nvec++; if (rdy_a !== 5'b00010) begin nerr++; $display("FAIL rr_C3_tail_ready got=%b want=00010", rdy_a); end
    tick(); in_valid[1] = 1'b0; in_tail[1] = 1'b0; #1;
    nvec++; if (sel_a[24:20] !== 5'b00000) begin nerr++; $display("FAIL rr_C4_bubble got=%b want=00000", sel_a[24:20]); end
    nvec++; if (dut.g_out[4].rr_ptr_reg !== 3'd2) begin nerr++; $display("FAIL rr_ptr_after_north got=%0d want=2", dut.g_out[4].rr_ptr_reg); end
    tick();
    nvec++; if (sel_a[24:20] !== 5'b01000) begin nerr++; $display("FAIL rr_C5_south_sel got=%b want=01000", sel_a[24:20]); end
    nvec++; if (rdy_a !== 5'b01000) begin nerr++; $display("FAIL rr_C5_ready got=%b want=01000", rdy_a); end
    tick(); in_head[3] = 1'b0; #1;
    tick(); in_tail[3] = 1'b1; #1;
    tick(); in_valid[3] = 1'b0; in_tail[3] = 1'b0; #1;
    nvec++; if (sel_a[24:20] !== 5'b00000) begin nerr++; $display("FAIL rr_C8_idle got=%b want=00000", sel_a[24:20]); end
    nvec++; if (dut.g_out[4].rr_ptr_reg !== 3'd4) begin nerr++; $display("FAIL rr_ptr_after_south got=%0d want=4", dut.g_out[4].rr_ptr_reg); end
    $display("test_round_robin done");
  endtask

  // EAST dest 0 and NORTH dest 2 at once, observed on all three routers
  task automatic test_corner_routes();
    do_reset();
    in_valid = 5'b00110; in_head = 5'b00110; in_tail = 5'b00110;
    in_dest[7:4] = 4'd2; in_dest[11:8] = 4'd0;
    tick();
    nvec++; if (sel_b[4:0] !== 5'b00100) begin nerr++; $display("FAIL id0_local_sel got=%b want=00100", sel_b[4:0]); end
    nvec++; if (sel_b[14:10] !== 5'b00010) begin nerr++; $display("FAIL id0_east_sel got=%b want=00010", sel_b[14:10]); end
    nvec++; if (sel_c[9:5] !== 5'b00010) begin nerr++; $display("FAIL id8_north_sel got=%b want=00010", sel_c[9:5]); end
    nvec++; if (sel_c[24:20] !== 5'b00100) begin nerr++; $display("FAIL id8_west_sel got=%b want=00100", sel_c[24:20]); end
    nvec++; if (ov_a !== 5'b10100) begin nerr++; $display("FAIL id4_dual_out_valid got=%b want=10100", ov_a); end
    tick();
    clear_inputs();
    #1;
    nvec++; if ({sel_a, sel_b, sel_c} !== 75'd0) begin nerr++; $display("FAIL corner_all_idle got=%h want=0", {sel_a, sel_b, sel_c}); end
    $display("test_corner_routes done");
  endtask

  // 3-flit packet with a 5-cycle downstream stall and a 1-cycle source bubble
  task automatic test_stall();
    int xfers;
    xfers = 0;
    do_reset();
    in_valid[0] = 1'b1; in_head[0] = 1'b1; in_dest[3:0] = 4'd5;
    tick(); #1;
    if (rdy_a[0] & in_valid[0]) xfers++;
    tick(); in_head[0] = 1'b0; out_ready[2] = 1'b0; #1;
    for (int c = 0; c < 5; c++) begin
      nvec++; if (rdy_a[0] !== 1'b0) begin nerr++; $display("FAIL stall_ready_c%0d got=%b want=0", c, rdy_a[0]); end
      nvec++; if (sel_a[14:10] !== 5'b00001) begin nerr++; $display("FAIL stall_lock_c%0d got=%b want=00001", c, sel_a[14:10]); end
      if (rdy_a[0] & in_valid[0]) xfers++;
      tick();
    end
    out_ready[2] = 1'b1; in_valid[0] = 1'b0; #1;
    nvec++; if (ov_a[2] !== 1'b0) begin nerr++; $display("FAIL bubble_out_valid got=%b want=0", ov_a[2]); end
    nvec++; if (sel_a[14:10] !== 5'b00001) begin nerr++; $display("FAIL bubble_lock got=%b want=00001", sel_a[14:10]); end
    tick(); in_valid[0] = 1'b1; #1;
    nvec++; if (rdy_a[0] !== 1'b1) begin nerr++; $display("FAIL resume_ready got=%b want=1", rdy_a[0]); end
    if (rdy_a[0] & in_valid[0]) xfers++;
    tick(); in_tail[0] = 1'b1; #1;
    if (rdy_a[0] & in_valid[0]) xfers++;
    tick(); clear_inputs(); #1;
    nvec++; if (xfers !== 3) begin nerr++; $display("FAIL stall_flit_count got=%0d want=3", xfers); end
    nvec++; if (sel_a[14:10] !== 5'b00000) begin nerr++; $display("FAIL stall_release got=%b want=00000", sel_a[14:10]); end
    $display("test_stall done");
  endtask

  // Asynchronous reset while locked, then a fresh allocation
  task automatic test_async_reset();
    do_reset();
    in_valid[0] = 1'b1; in_head[0] = 1'b1; in_dest[3:0] = 4'd5;
    tick();
    nvec++; if (ov_a !== 5'b00100) begin nerr++; $display("FAIL areset_pre_lock got=%b want=00100", ov_a); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if ({ov_a, rdy_a} !== 10'd0) begin nerr++; $display("FAIL areset_outputs got=%b want=0", {ov_a, rdy_a}); end
    nvec++; if (sel_a !== 25'd0) begin nerr++; $display("FAIL areset_sel got=%h want=0", sel_a); end
    #1 rst_n = 1'b1;
    in_valid = 5'b00010; in_head = 5'b00010; in_tail = 5'b00010; in_dest[7:4] = 4'd1;
    tick();
    nvec++; if (sel_a[9:5] !== 5'b00010) begin nerr++; $display("FAIL areset_realloc got=%b want=00010", sel_a[9:5]); end
    tick(); clear_inputs(); #1;
    $display("test_async_reset done");
  endtask

  // Long downstream stall; wd_err is sticky only in the watchdog build
  task automatic test_watchdog();
    do_reset();
    in_valid[0] = 1'b1; in_head[0] = 1'b1; in_tail[0] = 1'b1; in_dest[3:0] = 4'd5;
    out_ready[2] = 1'b0;
    tick();
    repeat (200) tick();
    nvec++; if (wd_a !== 1'b0) begin nerr++; $display("FAIL wd_early got=%b want=0", wd_a); end
    repeat (60) tick();
    nvec++; if (wd_a !== WD_ON) begin nerr++; $display("FAIL wd_raised got=%b want=%b", wd_a, WD_ON); end
    out_ready = 5'b11111;
    tick(); clear_inputs(); repeat (3) tick();
    nvec++; if (wd_a !== WD_ON) begin nerr++; $display("FAIL wd_sticky got=%b want=%b", wd_a, WD_ON); end
    nvec++; if (sel_a !== 25'd0) begin nerr++; $display("FAIL wd_routing got=%h want=0", sel_a); end
    do_reset();
    nvec++; if (wd_a !== 1'b0) begin nerr++; $display("FAIL wd_cleared got=%b want=0", wd_a); end
    $display("test_watchdog done");
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_flit();
    test_round_robin();
    test_corner_routes();
    test_stall();
    test_async_reset();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
